// File: rtl/sm3_stream_hash_ctrl_if.sv
// Stream, compression-core and digest signals of sm3_stream_hash_ctrl.
// Optional resume signals exist only when SM3_RESUME_EN is defined.
interface sm3_stream_hash_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int NB_W   = $clog2(DATA_W / 8) + 1
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [NB_W-1:0]   in_nbytes;
    logic              cf_start;
    logic [511:0]      cf_block;
    logic [255:0]      cf_v_in;
    logic              cf_done;
    logic [255:0]      cf_v_out;
    logic [255:0]      digest;
    logic              digest_valid;
    logic              digest_ready;
    logic              busy;
`ifdef SM3_RESUME_EN
    logic [255:0]      iv_in;
    logic [63:0]       len_in;
    logic              resume;
`endif

    modport slave (
        input  start, in_data, in_valid, in_last, in_nbytes, cf_done, cf_v_out, digest_ready,
`ifdef SM3_RESUME_EN
        input  iv_in, len_in, resume,
`endif
        output in_ready, cf_start, cf_block, cf_v_in, digest, digest_valid, busy
    );

    modport master (
        output start, in_data, in_valid, in_last, in_nbytes, cf_done, cf_v_out, digest_ready,
`ifdef SM3_RESUME_EN
        output iv_in, len_in, resume,
`endif
        input  in_ready, cf_start, cf_block, cf_v_in, digest, digest_valid, busy
    );
endinterface

// File: rtl/sm3_stream_hash_ctrl.sv
// SM3 streaming controller: block assembly, hardware padding and compression-core sequencing.
// Define SM3_RESUME_EN to allow starting from a saved chaining value and length.
module sm3_stream_hash_ctrl #(
    parameter int           DATA_W = 32,
    parameter int           NB_W   = $clog2(DATA_W / 8) + 1,
    parameter logic [255:0] IV     = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
) (
    input logic                   clk,
    input logic                   rst_n,
    sm3_stream_hash_ctrl_if.slave bus
);
    localparam int BPB   = DATA_W / 8;
    localparam int NSLOT = 512 / DATA_W;
    localparam int SH    = $clog2(BPB);

    typedef enum logic [2:0] {
        S_IDLE, S_ABSORB, S_CF_WAIT, S_PAD, S_PAD_CF_WAIT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   v_q, v_d;
    logic [63:0]    len_q, len_d;
    logic [6:0]     ptr_q, ptr_d;
    logic [511:0]   buf_q, buf_d;
    logic           last_seen_q, last_seen_d;
    logic           pad2_q, pad2_d;
    logic           cf_start_q, cf_start_d;
    logic [255:0]   digest_q, digest_d;

    logic [NB_W-1:0] last_nb;
    logic [6:0]      nbytes;
    logic [6:0]      ptr_sum;
    logic [5:0]      slot;
    logic [511:0]    pad_blk;

    assign last_nb = bus.in_nbytes;
    assign nbytes  = bus.in_last ? 7'(last_nb) : 7'(BPB);
    assign ptr_sum = ptr_q + nbytes;
    assign slot    = 6'(ptr_q[5:SH]);

    // Pad block: message bytes below ptr, 0x80 at ptr, zeros, length when it fits.
    // A pending second block (pad2_q) is zeros plus length only.
    always_comb begin
        pad_blk = '0;
        if (!pad2_q) begin
            for (int b = 0; b < 64; b++) begin
                if (7'(b) < ptr_q)       pad_blk[511-8*b -: 8] = buf_q[511-8*b -: 8];
                else if (7'(b) == ptr_q) pad_blk[511-8*b -: 8] = 8'h80;
            end
        end
        if (pad2_q || ptr_q <= 7'd55) pad_blk[63:0] = len_q;
    end

    // NOTE: every next-state signal takes its held value first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        buf_d       = buf_q;
        last_seen_d = last_seen_q;
        pad2_d      = pad2_q;
        digest_d    = digest_q;
        cf_start_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef SM3_RESUME_EN
                    v_d   = bus.resume ? bus.iv_in  : IV;
                    len_d = bus.resume ? bus.len_in : 64'd0;
`else
                    v_d   = IV;
                    len_d = 64'd0;
`endif
                    ptr_d       = 7'd0;
                    last_seen_d = 1'b0;
                    pad2_d      = 1'b0;
                    state_d     = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (bus.in_valid) begin
                    // Bytes beyond nbytes land in the buffer but are masked out by padding.
                    buf_d[(NSLOT - 1 - int'(slot)) * DATA_W +: DATA_W] = bus.in_data;
                    len_d = len_q + (64'(nbytes) << 3);
                    ptr_d = ptr_sum;
                    if (ptr_sum == 7'd64) begin
                        cf_start_d  = 1'b1;
                        last_seen_d = bus.in_last;
                        state_d     = S_CF_WAIT;
                    end else if (bus.in_last) begin
                        state_d = S_PAD;
                    end
                end
            end
            S_CF_WAIT: begin
                if (bus.cf_done) begin
                    v_d     = bus.cf_v_out;
                    ptr_d   = 7'd0;
                    state_d = last_seen_q ? S_PAD : S_ABSORB;
                end
            end
            S_PAD: begin
                buf_d      = pad_blk;
                cf_start_d = 1'b1;
                pad2_d     = !pad2_q && (ptr_q > 7'd55);
                state_d    = S_PAD_CF_WAIT;
            end
            S_PAD_CF_WAIT: begin
                if (bus.cf_done) begin
                    v_d = bus.cf_v_out;
                    if (pad2_q) begin
                        state_d = S_PAD;
                    end else begin
                        digest_d = bus.cf_v_out;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.digest_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            v_q         <= IV;
            len_q       <= '0;
            ptr_q       <= '0;
            // NOTE: the block buffer is reset too because it drives cf_block directly.
            buf_q       <= '0;
            last_seen_q <= 1'b0;
            pad2_q      <= 1'b0;
            cf_start_q  <= 1'b0;
            digest_q    <= '0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            buf_q       <= buf_d;
            last_seen_q <= last_seen_d;
            pad2_q      <= pad2_d;
            cf_start_q  <= cf_start_d;
            digest_q    <= digest_d;
        end
    end

    assign bus.in_ready     = (state_q == S_ABSORB);
    assign bus.cf_start     = cf_start_q;
    assign bus.cf_block     = buf_q;
    assign bus.cf_v_in      = v_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_sm3_stream_hash_ctrl.sv
// Bench for sm3_stream_hash_ctrl: SM3 compression-core model plus block/digest scoreboards.
module tb_sm3_stream_hash_ctrl;
    localparam int           DATA_W = 32;
    localparam logic [255:0] IV     = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [255:0] DIG_ABC   = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
    localparam logic [255:0] DIG_ABCD  = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
    localparam logic [255:0] DIG_EMPTY = 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm3_stream_hash_ctrl_if #(.DATA_W(DATA_W)) bus ();
    sm3_stream_hash_ctrl #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [511:0] blk_q[$];
    logic [255:0] dig_q[$];
    int cf_cnt = 0;
    int core_lat_min = 1;
    int core_lat_max = 4;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int s = n % 32;
        return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w[68];
        logic [31:0] w1[64];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
            ss2 = ss1 ^ rotl(a, 12);
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + w1[j];
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rotl(b, 9); b = a; a = tt1;
            h = g; g = rotl(f, 19); f = e; e = p0(tt2);
        end
        return {a, b, c, d, e, f, g, h} ^ v;
    endfunction

    function automatic void str_to_q(input string s, output byte unsigned q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Software padding of the whole message; pushes expected blocks and the digest.
    task automatic build_expect(input byte unsigned msg[$], input bit use_const,
                                input logic [255:0] cdig, output int nblk);
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] v;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        v = IV;
        for (int k = 0; k < nblk; k++) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*k+i];
            blk_q.push_back(blk);
            v = sm3_cf(v, blk);
        end
        dig_q.push_back(use_const ? cdig : v);
    endtask

    // Compression-core model: checks each launched block, answers after a random latency.
    initial begin : core_model
        logic [511:0] cap_blk;
        logic [255:0] cap_v;
        logic [511:0] exp_blk;
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        bus.cf_done  = 1'b0;
        bus.cf_v_out = '0;
        forever begin
            @(negedge clk);
            if (bus.cf_done) bus.cf_done = 1'b0;
            if (pend) begin
                if (bus.cf_start === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL cf_start_reassert: got cf_start=1 expected 0 before cf_done");
                end
                if (bus.busy === 1'b1 && bus.cf_block !== cap_blk) begin
                    checks++; errors++;
                    $display("FAIL cf_block_stable: got %h expected %h", bus.cf_block, cap_blk);
                end
                cnt--;
                if (cnt <= 0) begin
                    bus.cf_v_out = sm3_cf(cap_v, cap_blk);
                    bus.cf_done  = 1'b1;
                    pend = 1'b0;
                end
            end else if (bus.cf_start === 1'b1) begin
                cap_blk = bus.cf_block;
                cap_v   = bus.cf_v_in;
                cf_cnt++;
                checks++;
                if (blk_q.size() == 0) begin
                    errors++;
                    $display("FAIL cf_block_unexpected: got block %h expected no cf_start", cap_blk);
                end else begin
                    exp_blk = blk_q.pop_front();
                    if (cap_blk !== exp_blk) begin
                        errors++;
                        $display("FAIL cf_block: got %h expected %h", cap_blk, exp_blk);
                    end
                end
                pend = 1'b1;
                cnt  = $urandom_range(core_lat_max, core_lat_min);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit last, input logic [2:0] nb, output bit ok);
        int to = 0;
        ok = 1'b1;
        repeat ($urandom_range(1, 0)) @(negedge clk);
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        bus.in_valid  = 1'b1;
        while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            to++;
            if (to > 200) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got no accept in %0d cycles expected accept", to);
                bus.in_valid = 1'b0;
                ok = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // mode 0: normal last beat; 1: full beats then a zero-byte last beat; 2: no last at all.
    task automatic send_msg(input byte unsigned msg[$], input int mode, output bit ok);
        int n, nbeats, nlast, idx;
        bit b_ok, is_last;
        logic [31:0] d;
        ok = 1'b1;
        n = msg.size();
        if (n == 0) begin
            nbeats = 1; nlast = 0;
        end else begin
            nbeats = (n + 3) / 4; nlast = n - 4 * (nbeats - 1);
        end
        for (int k = 0; k < nbeats; k++) begin
            for (int i = 0; i < 4; i++) begin
                idx = 4 * k + i;
                d[31-8*i -: 8] = (idx < n) ? msg[idx] : 8'($urandom);
            end
            is_last = (k == nbeats - 1);
            if (mode == 2 || (is_last && mode == 1)) send_beat(d, 1'b0, 3'd0, b_ok);
            else send_beat(d, is_last, is_last ? 3'(nlast) : 3'd0, b_ok);
            ok &= b_ok;
            if (is_last && mode == 1) begin
                send_beat($urandom, 1'b1, 3'd0, b_ok);
                ok &= b_ok;
            end
        end
    endtask

    task automatic start_msg(input string name);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_busy: got %b expected 1", name, bus.busy);
        end
    endtask

    task automatic wait_digest(input string name, output bit ok);
        int to = 0;
        while (bus.digest_valid !== 1'b1 && to < 3000) begin
            @(negedge clk);
            to++;
        end
        ok = (bus.digest_valid === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s digest_timeout: got digest_valid=%b expected 1", name, bus.digest_valid);
        end
    endtask

    task automatic run_msg(input string name, input byte unsigned msg[$], input int mode,
                           input bit use_const, input logic [255:0] cdig);
        int nblk;
        bit ok;
        logic [255:0] exp;
        build_expect(msg, use_const, cdig, nblk);
        cf_cnt = 0;
        start_msg(name);
        send_msg(msg, mode, ok);
        wait_digest(name, ok);
        exp = dig_q.pop_front();
        if (!ok) begin
            blk_q.delete(); dig_q.delete();
            return;
        end
        checks++;
        if (bus.digest !== exp) begin
            errors++;
            $display("FAIL %s digest: got %h expected %h", name, bus.digest, exp);
        end
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        checks++;
        if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got valid=%b busy=%b expected 0 0", name, bus.digest_valid, bus.busy);
        end
        checks++;
        if (cf_cnt !== nblk) begin
            errors++;
            $display("FAIL %s cf_start_count: got %0d expected %0d", name, cf_cnt, nblk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.cf_start, bus.digest_valid, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got in_ready,cf_start,digest_valid,busy=%b expected 0000",
                     {bus.in_ready, bus.cf_start, bus.digest_valid, bus.busy});
        end
        checks++;
        if ({bus.digest, bus.cf_v_in, bus.cf_block} !== {256'd0, IV, 512'd0}) begin
            errors++;
            $display("FAIL reset_data: got digest=%h v=%h block=%h", bus.digest, bus.cf_v_in, bus.cf_block);
        end
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_over_start: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_known_vectors();
        byte unsigned m[$];
        str_to_q("abc", m);
        run_msg("abc", m, 0, 1'b1, DIG_ABC);
        str_to_q("abcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcdabcd", m);
        run_msg("abcd64", m, 0, 1'b1, DIG_ABCD);
        m = {};
        run_msg("empty", m, 0, 1'b1, DIG_EMPTY);
    endtask

    task automatic test_boundaries();
        byte unsigned m[$];
        int lens[6] = '{55, 56, 57, 63, 65, 128};
        foreach (lens[i]) begin
            m = {};
            for (int k = 0; k < lens[i]; k++) m.push_back(8'($urandom));
            run_msg($sformatf("len%0d", lens[i]), m, 0, 1'b0, '0);
        end
        m = {};
        for (int k = 0; k < 64; k++) m.push_back(8'(k));
        run_msg("zero_tail64", m, 1, 1'b0, '0);
    endtask

    task automatic test_digest_stall();
        byte unsigned m[$];
        int nblk;
        bit ok;
        logic [255:0] exp;
        str_to_q("abc", m);
        build_expect(m, 1'b1, DIG_ABC, nblk);
        cf_cnt = 0;
        start_msg("stall");
        send_msg(m, 0, ok);
        wait_digest("stall", ok);
        exp = dig_q.pop_front();
        for (int c = 0; c < 20; c++) begin
            bus.start = (c == 5 || c == 12);
            checks++;
            if (bus.digest_valid !== 1'b1 || bus.digest !== exp) begin
                errors++;
                $display("FAIL stall_hold c%0d: got valid=%b digest=%h expected 1 %h", c, bus.digest_valid, bus.digest, exp);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        checks++;
        if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: got valid=%b busy=%b expected 0 0", bus.digest_valid, bus.busy);
        end
        checks++;
        if (cf_cnt !== nblk) begin
            errors++;
            $display("FAIL stall cf_start_count: got %0d expected %0d", cf_cnt, nblk);
        end
    endtask

    task automatic test_reset_mid();
        byte unsigned m[$];
        int nblk;
        bit ok;
        core_lat_min = 8;
        core_lat_max = 8;
        m = {};
        for (int k = 0; k < 64; k++) m.push_back(8'($urandom));
        build_expect(m, 1'b0, '0, nblk);
        start_msg("reset_mid");
        send_msg(m, 2, ok);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.in_ready, bus.cf_start, bus.digest_valid, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got %b expected 0000",
                     {bus.in_ready, bus.cf_start, bus.digest_valid, bus.busy});
        end
        checks++;
        if ({bus.digest, bus.cf_v_in, bus.cf_block} !== {256'd0, IV, 512'd0}) begin
            errors++;
            $display("FAIL reset_mid_data: got digest=%h v=%h block=%h", bus.digest, bus.cf_v_in, bus.cf_block);
        end
        blk_q.delete();
        dig_q.delete();
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cf_v_in !== IV || bus.digest_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_cf_done: got busy=%b v=%h valid=%b expected 0 IV 0", bus.busy, bus.cf_v_in, bus.digest_valid);
        end
        core_lat_min = 1;
        core_lat_max = 4;
        str_to_q("abc", m);
        run_msg("abc_after_reset", m, 0, 1'b1, DIG_ABC);
    endtask

    task automatic test_back_to_back();
        byte unsigned m[$];
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(130, 1);
            m = {};
            for (int k = 0; k < n; k++) m.push_back(8'($urandom));
            run_msg($sformatf("b2b%0d_len%0d", r, n), m, 0, 1'b0, '0);
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.in_nbytes    = '0;
        bus.digest_ready = 1'b0;
`ifdef SM3_RESUME_EN
        bus.iv_in  = '0;
        bus.len_in = '0;
        bus.resume = 1'b0;
`endif
        test_reset();
        test_known_vectors();
        test_boundaries();
        test_digest_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no completion expected completion within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sm3_stream_hash_ctrl.md
Name: sm3_stream_hash_ctrl

Overview:
Parametrised successor to the SM3 top-level controller. It accepts an arbitrary-length message as a stream of DATA_W-bit beats and assembles 512-bit blocks. It performs SM3 padding in hardware, using an internal bit-length counter. It sequences an external SM3 compression core through a start/done handshake with chained V, and returns the 256-bit digest through a valid/ready handshake.

Parameters:
DATA_W, 32, input beat width in bits; legal values 8, 32, 64; must divide 512.
NB_W, $clog2(DATA_W/8)+1, width of in_nbytes (derived; do not override).
IV, 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e, SM3 initial vector.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; begins a new message; ignored unless in IDLE.
in_data  in  DATA_W  message beat; first byte in MSBs (big-endian).
in_valid  in  1  beat valid.
in_ready  out  1  beat accepted when in_valid & in_ready.
in_last  in  1  final beat of the message.
in_nbytes  in  NB_W  valid bytes in the last beat, 0..DATA_W/8; sampled only with in_last; 0 allowed only for an empty message or an exact-fill tail.
cf_start  out  1  one-cycle pulse; launches the compression core.
cf_block  out  512  block to compress; held stable from cf_start until cf_done.
cf_v_in  out  256  chaining value for the compression core.
cf_done  in  1  one-cycle pulse; cf_v_out valid.
cf_v_out  in  256  new chaining value.
digest  out  256  final hash.
digest_valid  out  1  digest available.
digest_ready  in  1  digest consumed when valid & ready.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (rst_n=0 at posedge): state IDLE; in_ready=0; cf_start=0; digest_valid=0; digest=0; busy=0; V=IV; byte counter=0; length=0; block buffer=0. Reset mid-operation aborts immediately. A cf_done arriving after reset is ignored.
- States: IDLE, ABSORB, CF_WAIT, PAD, PAD_CF_WAIT, DONE.
- IDLE: start -> V=IV, length=0, byte ptr=0, go to ABSORB.
- ABSORB: in_ready=1. On each accepted beat:
  - write nbytes bytes at byte ptr; nbytes=DATA_W/8, or in_nbytes when in_last.
  - length += 8*nbytes, as a 64-bit counter that wraps mod 2^64.
  - If ptr reaches 64: pulse cf_start next cycle, go to CF_WAIT, in_ready=0. Remember whether in_last was seen.
  - If in_last and the block is not full: go to PAD.
- CF_WAIT: on cf_done, V<=cf_v_out and ptr=0. If last was seen, go to PAD; otherwise return to ABSORB. Bubble is 1 cycle minimum between cf_done and the next accepted beat.
- PAD, single cycle, builds the pad block from the remaining bytes:
  - Write 0x80 at ptr, then zeros.
  - If ptr<=55: length (big-endian) goes in bytes 56..63; final block.
  - If ptr>55: this block is zeros only, then a second block follows with zeros and the length.
  - Exact-fill case (ptr=0 after CF_WAIT): a single block of 0x80 + zeros + length.
- Each pad block: pulse cf_start, enter PAD_CF_WAIT. On cf_done, V<=cf_v_out. Then go to PAD for the second block if one is pending, else to DONE with digest<=cf_v_out.
- DONE: digest_valid=1, digest held stable until digest_ready. On handshake: digest_valid=0 next cycle, go to IDLE. start in DONE is ignored.
- cf_v_in = V at all times. cf_start is never re-asserted before cf_done.
- Simultaneous start and reset: reset wins.

Optional Feature:
Macro SM3_RESUME_EN.
- Defined: adds ports iv_in (in, 256), len_in (in, 64) and resume (in, 1). When start and resume are both high in IDLE, V loads iv_in and length loads len_in instead of IV and 0. This supports continuing a hash from a saved mid-state. len_in must be a multiple of 512.
- Not defined: ports absent; start always loads IV and length 0.

Test Plan:
- DATA_W=8, start, bytes "abc", last with in_nbytes=1 -> exactly 1 cf_start; digest=66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- DATA_W=32, 16 beats of "abcd", last beat with in_nbytes=4 -> 2 cf_starts, the second block = 0x80 + zeros + length 0x200; digest=debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- Empty message: start, then a single beat with in_last and in_nbytes=0 -> 1 block, length 0; digest=1ab21d83 55cfa17f 8e611948 31e81a8f 22bec8c7 28fefb74 7ed035eb 5082aa2b.
- 56-byte message -> 2 cf_starts; block 1 holds byte 56=0x80 and zeros; block 2 holds zeros and length 0x1C0 in bytes 56..63.
- digest_ready held low 20 cycles -> digest_valid and digest stable throughout; start pulses meanwhile are ignored; IDLE is reached 1 cycle after the handshake.
- rst_n low for 1 cycle while in CF_WAIT, followed by a stray cf_done -> all outputs at reset values; a new "abc" message then hashes correctly.
